// File: rtl/ram_arb_pkg.sv
// Shared constants, state encoding and sizing helpers for the N-port
// Wishbone-classic RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Watchdog counter width; a disabled watchdog still keeps a 1-bit register.
    function automatic int unsigned wd_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

    // Width of a master index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_arb_n_rr_pick.sv
// Combinational N-wide priority picker: first asserted request at or above
// base, wrapping around, returned one-hot.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic [N-1:0]  win
);

    function automatic logic [IW-1:0] idx_of(input logic [IW-1:0] b, input int unsigned off);
        return IW'((32'(b) + off) % N);
    endfunction

    logic found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            if (!found && req[idx_of(base, off)]) begin
                win[idx_of(base, off)] = 1'b1;
                found                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arb_n.sv
// N-port Wishbone-classic arbiter sharing one downstream slave, with fixed or
// round-robin selection, abort handling and a stall watchdog.
module ram_arb_n
    import ram_arb_pkg::*;
#(
    parameter int unsigned N       = 3,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned MODE    = 0,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst_n,
    input  logic [N-1:0]          m_cyc,
    input  logic [N-1:0]          m_we,
    input  logic [4*N-1:0]        m_sel,
    input  logic [AWIDTH*N-1:0]   m_adr,
    input  logic [WIDTH*N-1:0]    m_dat,
    output logic [N-1:0]          m_ack,
    output logic [WIDTH*N-1:0]    m_rdt,
    output logic                  x_cyc,
    output logic                  x_we,
    output logic [3:0]            x_sel,
    output logic [AWIDTH-1:0]     x_adr,
    output logic [WIDTH-1:0]      x_dat,
    input  logic                  x_ack,
    input  logic [WIDTH-1:0]      x_rdt,
    output logic [N-1:0]          grant,
    output logic                  busy,
    output logic                  timeout
);

    localparam int unsigned IW = idx_width(N);
    localparam int unsigned CW = wd_width(TIMEOUT);

    state_e        state, state_nx;
    logic [N-1:0]  grant_nx, pick;
    logic [IW-1:0] last, last_nx, gidx, base;
    logic [CW-1:0] wd_cnt, wd_nx;
    logic          in_grant, cyc_g, ack_ok, wd_fire;

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            last   <= IW'(N - 1);
            wd_cnt <= '0;
        end else begin
            state  <= state_nx;
            grant  <= grant_nx;
            last   <= last_nx;
            wd_cnt <= wd_nx;
        end
    end

    // Search starts just past the previous owner in round-robin mode.
    always_comb begin
        base = '0;
        if (MODE == MODE_RR) begin
            base = (last == IW'(N - 1)) ? '0 : last + IW'(1);
        end
    end

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req  (m_cyc),
        .base (base),
        .win  (pick)
    );

    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) gidx = IW'(i);
        end
    end

    // Request mux; an all-zero grant in IDLE leaves every field at 0.
    always_comb begin
        cyc_g = 1'b0;
        x_we  = 1'b0;
        x_sel = '0;
        x_adr = '0;
        x_dat = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                cyc_g = m_cyc[i];
                x_we  = m_we[i];
                x_sel = m_sel[4*i +: 4];
                x_adr = m_adr[AWIDTH*i +: AWIDTH];
                x_dat = m_dat[WIDTH*i +: WIDTH];
            end
        end
    end

    assign in_grant = (state == GRANT);
    assign ack_ok   = in_grant && cyc_g && x_ack;
    // A real ack in the expiry cycle takes precedence over the watchdog.
    assign wd_fire  = (TIMEOUT != 0) && in_grant && cyc_g && !x_ack &&
                      (wd_cnt == CW'(TIMEOUT - 1));

    assign x_cyc   = cyc_g && !wd_fire;
    assign busy    = in_grant;
    assign timeout = wd_fire;
    assign m_ack   = grant & {N{ack_ok || wd_fire}};

    always_comb begin
        m_rdt = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i] && ack_ok) m_rdt[WIDTH*i +: WIDTH] = x_rdt;
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        last_nx  = last;
        wd_nx    = wd_cnt;
        case (state)
            IDLE: begin
                if (|m_cyc) begin
                    state_nx = GRANT;
                    grant_nx = pick;
                    wd_nx    = '0;
                end
            end
            GRANT: begin
                if (x_ack || !cyc_g || wd_fire) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    last_nx  = gidx;
                    wd_nx    = '0;
                end else begin
                    wd_nx = wd_cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arb_n.sv
// Bench for ram_arb_n: a fixed-priority and a round-robin instance share the
// master inputs and are checked every cycle against a transaction-level model.
module tb_ram_arb_n;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [N-1:0]         m_cyc, m_we;
    logic [4*N-1:0]       m_sel;
    logic [AW*N-1:0]      m_adr;
    logic [W*N-1:0]       m_dat;
    logic [1:0]           x_ack_i;
    logic [1:0][W-1:0]    x_rdt_i;

    logic [1:0][N-1:0]    m_ack_o, grant_o;
    logic [1:0][W*N-1:0]  m_rdt_o;
    logic [1:0]           x_cyc_o, x_we_o, busy_o, to_o;
    logic [1:0][3:0]      x_sel_o;
    logic [1:0][AW-1:0]   x_adr_o;
    logic [1:0][W-1:0]    x_dat_o;

    ram_arb_n #(.N(N), .WIDTH(W), .AWIDTH(AW), .MODE(0), .TIMEOUT(TO)) u_fix (
        .wb_clk(clk), .wb_rst_n(rst_n),
        .m_cyc(m_cyc), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr), .m_dat(m_dat),
        .m_ack(m_ack_o[0]), .m_rdt(m_rdt_o[0]),
        .x_cyc(x_cyc_o[0]), .x_we(x_we_o[0]), .x_sel(x_sel_o[0]), .x_adr(x_adr_o[0]),
        .x_dat(x_dat_o[0]), .x_ack(x_ack_i[0]), .x_rdt(x_rdt_i[0]),
        .grant(grant_o[0]), .busy(busy_o[0]), .timeout(to_o[0])
    );

    ram_arb_n #(.N(N), .WIDTH(W), .AWIDTH(AW), .MODE(1), .TIMEOUT(TO)) u_rr (
        .wb_clk(clk), .wb_rst_n(rst_n),
        .m_cyc(m_cyc), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr), .m_dat(m_dat),
        .m_ack(m_ack_o[1]), .m_rdt(m_rdt_o[1]),
        .x_cyc(x_cyc_o[1]), .x_we(x_we_o[1]), .x_sel(x_sel_o[1]), .x_adr(x_adr_o[1]),
        .x_dat(x_dat_o[1]), .x_ack(x_ack_i[1]), .x_rdt(x_rdt_i[1]),
        .grant(grant_o[1]), .busy(busy_o[1]), .timeout(to_o[1])
    );

    int total = 0;
    int bad   = 0;

    // Model: current owner (-1 = none), previous owner, cycles spent owning.
    int owner [2];
    int last  [2];
    int gcnt  [2];
    logic [N-1:0] e_ack_q  [2];
    logic         e_xcyc_q [2];
    logic         prev_busy[2];
    logic auto_slave, drop_on_ack;
    int cyc_no;
    int q_idx0[$], q_idx1[$], q_cyc0[$], q_cyc1[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Fixed: lowest request. Round robin: first request after the previous owner.
    function automatic int pick(input int d, input logic [N-1:0] req);
        if (d == 0) begin
            for (int i = 0; i < N; i++) if (req[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) if (req[(last[d] + k) % N]) return (last[d] + k) % N;
        end
        return -1;
    endfunction

    task automatic check_dut(input int d);
        logic [N-1:0]   e_grant, e_ack;
        logic [W*N-1:0] e_rdt;
        logic           e_xcyc, e_we, e_busy, e_to, cg, ack, fire;
        logic [3:0]     e_sel;
        logic [AW-1:0]  e_adr;
        logic [W-1:0]   e_dat;
        int g;
        g = owner[d];
        e_grant = '0; e_ack = '0; e_rdt = '0; e_xcyc = 0; e_we = 0; e_busy = 0; e_to = 0;
        e_sel = '0; e_adr = '0; e_dat = '0; cg = 0; ack = 0; fire = 0;
        if (g >= 0) begin
            cg       = m_cyc[g];
            ack      = x_ack_i[d] && cg;
            fire     = cg && !x_ack_i[d] && (gcnt[d] == TO);
            e_busy   = 1'b1;
            e_grant[g] = 1'b1;
            e_xcyc   = cg && !fire;
            e_we     = m_we[g];
            e_sel    = m_sel[4*g +: 4];
            e_adr    = m_adr[AW*g +: AW];
            e_dat    = m_dat[W*g +: W];
            e_ack[g] = ack || fire;
            if (ack) e_rdt[W*g +: W] = x_rdt_i[d];
            e_to     = fire;
        end
        e_ack_q[d]  = e_ack;
        e_xcyc_q[d] = e_xcyc;
        chk($sformatf("d%0d grant", d),   128'(grant_o[d]), 128'(e_grant));
        chk($sformatf("d%0d busy", d),    128'(busy_o[d]),  128'(e_busy));
        chk($sformatf("d%0d timeout", d), 128'(to_o[d]),    128'(e_to));
        chk($sformatf("d%0d x_cyc", d),   128'(x_cyc_o[d]), 128'(e_xcyc));
        chk($sformatf("d%0d x_we", d),    128'(x_we_o[d]),  128'(e_we));
        chk($sformatf("d%0d x_sel", d),   128'(x_sel_o[d]), 128'(e_sel));
        chk($sformatf("d%0d x_adr", d),   128'(x_adr_o[d]), 128'(e_adr));
        chk($sformatf("d%0d x_dat", d),   128'(x_dat_o[d]), 128'(e_dat));
        chk($sformatf("d%0d m_ack", d),   128'(m_ack_o[d]), 128'(e_ack));
        chk($sformatf("d%0d m_rdt", d),   128'(m_rdt_o[d]), 128'(e_rdt));
    endtask

    task automatic step_model(input int d);
        if (!rst_n) begin
            owner[d] = -1; last[d] = N - 1; gcnt[d] = 0;
        end else if (owner[d] < 0) begin
            if (m_cyc != '0) begin owner[d] = pick(d, m_cyc); gcnt[d] = 1; end
        end else if (x_ack_i[d] || !m_cyc[owner[d]] || gcnt[d] == TO) begin
            last[d] = owner[d]; owner[d] = -1;
        end else begin
            gcnt[d]++;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_dut(d);
            if (busy_o[d] === 1'b1 && !prev_busy[d]) begin
                if (d == 0) begin q_idx0.push_back(oh2i(grant_o[0])); q_cyc0.push_back(cyc_no); end
                else        begin q_idx1.push_back(oh2i(grant_o[1])); q_cyc1.push_back(cyc_no); end
            end
            prev_busy[d] = (busy_o[d] === 1'b1);
        end
        cyc_no++;
    endtask

    // sp_ram-like slave acks one cycle after x_cyc; masters may drop on ack.
    task automatic advance();
        for (int d = 0; d < 2; d++) step_model(d);
        @(posedge clk);
        #1;
        if (drop_on_ack) m_cyc = m_cyc & ~e_ack_q[0];
        if (auto_slave) begin
            for (int d = 0; d < 2; d++) begin
                x_ack_i[d] = e_xcyc_q[d] & ~x_ack_i[d];
                x_rdt_i[d] = $urandom;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; m_cyc = '0; x_ack_i = '0; auto_slave = 0; drop_on_ack = 0;
        sample(); advance();
        rst_n = 1'b1;
        q_idx0.delete(); q_idx1.delete(); q_cyc0.delete(); q_cyc1.delete();
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk($sformatf("%s d%0d grant", tag, d), 128'(grant_o[d]), 128'(0));
        chk($sformatf("%s d%0d busy", tag, d),  128'(busy_o[d]),  128'(0));
        chk($sformatf("%s d%0d x_cyc", tag, d), 128'(x_cyc_o[d]), 128'(0));
        chk($sformatf("%s d%0d x_adr", tag, d), 128'(x_adr_o[d]), 128'(0));
        chk($sformatf("%s d%0d m_ack", tag, d), 128'(m_ack_o[d]), 128'(0));
        chk($sformatf("%s d%0d m_rdt", tag, d), 128'(m_rdt_o[d]), 128'(0));
        chk($sformatf("%s d%0d to", tag, d),    128'(to_o[d]),    128'(0));
    endtask

    initial begin
        logic [W*N-1:0] rdt_exp;
        rst_n = 1'b0; m_cyc = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
        x_ack_i = '0; x_rdt_i = '0; auto_slave = 0; drop_on_ack = 0; cyc_no = 0;
        for (int d = 0; d < 2; d++) begin
            owner[d] = -1; last[d] = N - 1; gcnt[d] = 0;
            e_ack_q[d] = '0; e_xcyc_q[d] = 0; prev_busy[d] = 0;
        end
        @(posedge clk);
        #1;
        sample();
        for (int d = 0; d < 2; d++) chk_zero(d, "reset");
        advance();
        rst_n = 1'b1;

        // Single master read
        m_cyc = 3'b010; m_sel[4 +: 4] = 4'hF; m_adr[AW +: AW] = 32'h0000_0010;
        sample(); advance();
        sample();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("single d%0d x_cyc", d), 128'(x_cyc_o[d]), 128'(1));
            chk($sformatf("single d%0d x_adr", d), 128'(x_adr_o[d]), 128'(32'h10));
            chk($sformatf("single d%0d early ack", d), 128'(m_ack_o[d]), 128'(0));
        end
        advance();
        x_ack_i = 2'b11; x_rdt_i[0] = 32'hDEADBEEF; x_rdt_i[1] = 32'hDEADBEEF;
        rdt_exp = {32'h0, 32'hDEADBEEF, 32'h0};
        sample();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("single d%0d ack", d), 128'(m_ack_o[d]), 128'(3'b010));
            chk($sformatf("single d%0d rdt", d), 128'(m_rdt_o[d]), 128'(rdt_exp));
        end
        advance();
        m_cyc = '0; x_ack_i = '0;
        sample();
        for (int d = 0; d < 2; d++) chk_zero(d, "single after");
        advance();

        // Fixed priority, masters release after being served
        do_reset();
        m_cyc = 3'b111; auto_slave = 1; drop_on_ack = 1;
        repeat (12) begin sample(); advance(); end
        auto_slave = 0; drop_on_ack = 0; x_ack_i = '0; m_cyc = '0;
        chk("fixed count", 128'(q_idx0.size()), 128'(3));
        for (int i = 0; i < q_idx0.size() && i < 3; i++)
            chk($sformatf("fixed order %0d", i), 128'(q_idx0[i]), 128'(i));
        for (int i = 0; i + 1 < q_cyc0.size(); i++)
            chk($sformatf("fixed spacing %0d", i), 128'(q_cyc0[i+1] - q_cyc0[i]), 128'(3));

        // Round robin, all masters request continuously
        do_reset();
        m_cyc = 3'b111; auto_slave = 1;
        repeat (28) begin sample(); advance(); end
        auto_slave = 0; x_ack_i = '0; m_cyc = '0;
        chk("rr count", 128'(q_idx1.size()), 128'(9));
        for (int i = 0; i < q_idx1.size() && i < 9; i++)
            chk($sformatf("rr order %0d", i), 128'(q_idx1[i]), 128'(i % 3));
        for (int i = 0; i + 1 < q_cyc1.size(); i++)
            chk($sformatf("rr spacing %0d", i), 128'(q_cyc1[i+1] - q_cyc1[i]), 128'(3));
        chk("fixed under load count", 128'(q_idx0.size()), 128'(9));
        for (int i = 0; i < q_idx0.size() && i < 9; i++)
            chk($sformatf("fixed under load %0d", i), 128'(q_idx0[i]), 128'(0));

        // Abort with a late ack, then the next requester is served
        do_reset();
        m_cyc = 3'b100;
        sample(); advance();
        sample();
        for (int d = 0; d < 2; d++) chk($sformatf("abort d%0d grant", d), 128'(grant_o[d]), 128'(3'b100));
        advance();
        m_cyc = 3'b000;
        sample();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("abort d%0d ack", d), 128'(m_ack_o[d]), 128'(0));
            chk($sformatf("abort d%0d x_cyc", d), 128'(x_cyc_o[d]), 128'(0));
        end
        advance();
        x_ack_i = 2'b11; x_rdt_i[0] = 32'hA5A5_0001; x_rdt_i[1] = 32'hA5A5_0002; m_cyc = 3'b001;
        sample();
        for (int d = 0; d < 2; d++) chk_zero(d, "late ack");
        advance();
        x_ack_i = '0;
        sample();
        for (int d = 0; d < 2; d++) chk($sformatf("abort next d%0d grant", d), 128'(grant_o[d]), 128'(3'b001));
        advance();
        x_ack_i = 2'b11;
        sample();
        for (int d = 0; d < 2; d++) chk($sformatf("abort next d%0d ack", d), 128'(m_ack_o[d]), 128'(3'b001));
        advance();
        m_cyc = '0; x_ack_i = '0;

        // Watchdog expiry, then ack coinciding with expiry
        do_reset();
        m_cyc = 3'b001;
        sample(); advance();
        repeat (3) begin sample(); advance(); end
        sample();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("wd d%0d timeout", d), 128'(to_o[d]),    128'(1));
            chk($sformatf("wd d%0d ack", d),     128'(m_ack_o[d]), 128'(3'b001));
            chk($sformatf("wd d%0d rdt", d),     128'(m_rdt_o[d]), 128'(0));
            chk($sformatf("wd d%0d x_cyc", d),   128'(x_cyc_o[d]), 128'(0));
        end
        advance();
        sample();
        for (int d = 0; d < 2; d++) chk($sformatf("wd d%0d idle", d), 128'(busy_o[d]), 128'(0));
        advance();
        repeat (3) begin sample(); advance(); end
        x_ack_i = 2'b11; x_rdt_i[0] = 32'h1234_5678; x_rdt_i[1] = 32'h1234_5678;
        rdt_exp = {64'h0, 32'h1234_5678};
        sample();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("wd+ack d%0d timeout", d), 128'(to_o[d]),    128'(0));
            chk($sformatf("wd+ack d%0d ack", d),     128'(m_ack_o[d]), 128'(3'b001));
            chk($sformatf("wd+ack d%0d rdt", d),     128'(m_rdt_o[d]), 128'(rdt_exp));
        end
        advance();
        m_cyc = '0; x_ack_i = '0;

        // Reset while granted drops the in-flight ack and restores round-robin order
        do_reset();
        m_cyc = 3'b001;
        sample(); advance();
        x_ack_i = 2'b11;
        sample(); advance();
        x_ack_i = '0; m_cyc = 3'b100;
        sample(); advance();
        sample(); advance();
        rst_n = 1'b0; x_ack_i = 2'b11;
        sample(); advance();
        sample();
        for (int d = 0; d < 2; d++) chk_zero(d, "mid reset");
        advance();
        rst_n = 1'b1; x_ack_i = '0; m_cyc = 3'b111;
        sample(); advance();
        sample();
        for (int d = 0; d < 2; d++) chk($sformatf("post reset d%0d grant", d), 128'(grant_o[d]), 128'(3'b001));
        advance();
        m_cyc = '0;

        // Randomized traffic with occasional resets
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) m_cyc[i] = ~m_cyc[i];
            m_we  = N'($urandom);
            m_sel = (4*N)'($urandom);
            m_adr = {$urandom, $urandom, $urandom};
            m_dat = {$urandom, $urandom, $urandom};
            for (int d = 0; d < 2; d++) begin
                x_ack_i[d] = ($urandom_range(0, 3) == 0);
                x_rdt_i[d] = $urandom;
            end
            sample(); advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
